// File: rtl/qos_ctrl_fsm.sv
// qos_ctrl_fsm: init/flow-control FSM for a parametrised FIFO chain.
// Latches per-FIFO thresholds during INIT and tracks the global IDLE/ACTIVE/ERROR state.
// Also keeps a sticky per-FIFO error record and per-FIFO pause flags with hysteresis.
module qos_ctrl_fsm #(
    parameter int unsigned NUM_FIFO    = 5,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned IDLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [NUM_FIFO-1:0]       fifo_empty,
    input  logic [NUM_FIFO-1:0]       fifo_error,
    input  logic [NUM_FIFO*CNT_W-1:0] fifo_occ,
    input  logic [NUM_FIFO*CNT_W-1:0] umbral_high_in,
    input  logic [NUM_FIFO*CNT_W-1:0] umbral_low_in,
    output logic [NUM_FIFO*CNT_W-1:0] umbral_high_out,
    output logic [NUM_FIFO*CNT_W-1:0] umbral_low_out,
    output logic [2:0]                state_out,
    output logic                      idle_out,
    output logic                      active_out,
    output logic                      error_out,
    output logic [NUM_FIFO-1:0]       error_full,
    output logic [NUM_FIFO-1:0]       pause
);

    localparam int unsigned TW   = NUM_FIFO * CNT_W;
    localparam int unsigned IC_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IC_W-1:0] IDLE_MAX = IC_W'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [IC_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [TW-1:0]       high_q, high_d;
    logic [TW-1:0]       low_q, low_d;
    logic [NUM_FIFO-1:0] error_full_q, error_full_d;
    logic [NUM_FIFO-1:0] pause_q, pause_d;
    logic [NUM_FIFO-1:0] pause_upd;

    logic any_err;
    logic all_empty;

    assign any_err   = |fifo_error;
    assign all_empty = &fifo_empty;

    // Next state and idle qualifier: error beats init, init beats normal flow.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end
            ST_INIT: begin
                if (any_err) begin
                    state_d = ST_ERROR;
                end else if (!init) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (any_err) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (!all_empty) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_err) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (all_empty) begin
                    if (idle_cnt_q >= IDLE_MAX - IC_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IC_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Threshold latch (only while in INIT) and sticky error record.
    always_comb begin
        high_d       = (state_q == ST_INIT) ? umbral_high_in : high_q;
        low_d        = (state_q == ST_INIT) ? umbral_low_in  : low_q;
        error_full_d = error_full_q | ((state_q != ST_RESET) ? fifo_error : '0);
    end

    // Per-FIFO pause hysteresis; set wins when both bounds are met.
    always_comb begin
        pause_upd = pause_q;
        for (int i = 0; i < int'(NUM_FIFO); i++) begin
            if (fifo_occ[i*CNT_W +: CNT_W] >= high_q[i*CNT_W +: CNT_W]) begin
                pause_upd[i] = 1'b1;
            end else if (fifo_occ[i*CNT_W +: CNT_W] <= low_q[i*CNT_W +: CNT_W]) begin
                pause_upd[i] = 1'b0;
            end
        end
        case (state_q)
            ST_IDLE, ST_ACTIVE: pause_d = pause_upd;
            ST_ERROR:           pause_d = pause_q;
            default:            pause_d = '0;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RESET;
            idle_cnt_q   <= '0;
            high_q       <= '0;
            low_q        <= '0;
            error_full_q <= '0;
            pause_q      <= '0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            high_q       <= high_d;
            low_q        <= low_d;
            error_full_q <= error_full_d;
            pause_q      <= pause_d;
        end
    end

    assign umbral_high_out = high_q;
    assign umbral_low_out  = low_q;
    assign state_out       = state_q;
    assign idle_out        = (state_q == ST_IDLE);
    assign active_out      = (state_q == ST_ACTIVE);
    assign error_out       = (state_q == ST_ERROR);
    assign error_full      = error_full_q;
    assign pause           = pause_q;

endmodule

// File: tb/tb_qos_ctrl_fsm.sv
// Scoreboard bench for qos_ctrl_fsm: each stimulus step queues the hand-computed
// post-edge expectation, and a negedge monitor pops and compares it.
module tb_qos_ctrl_fsm;

    localparam int unsigned NF = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = NF * CW;

    localparam logic [TW-1:0] H9 = 20'h99999;
    localparam logic [TW-1:0] L3 = 20'h33333;
    localparam logic [TW-1:0] HD = 20'h99994;
    localparam logic [TW-1:0] LD = 20'h33336;
    localparam logic [TW-1:0] HZ = 20'h99990;
    localparam logic [TW-1:0] LZ = 20'h33330;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [NF-1:0] fifo_empty;
    logic [NF-1:0] fifo_error;
    logic [TW-1:0] fifo_occ;
    logic [TW-1:0] umbral_high_in;
    logic [TW-1:0] umbral_low_in;
    logic [TW-1:0] umbral_high_out;
    logic [TW-1:0] umbral_low_out;
    logic [2:0]    state_out;
    logic          idle_out;
    logic          active_out;
    logic          error_out;
    logic [NF-1:0] error_full;
    logic [NF-1:0] pause;

    qos_ctrl_fsm #(.NUM_FIFO(NF), .CNT_W(CW), .IDLE_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .fifo_empty     (fifo_empty),
        .fifo_error     (fifo_error),
        .fifo_occ       (fifo_occ),
        .umbral_high_in (umbral_high_in),
        .umbral_low_in  (umbral_low_in),
        .umbral_high_out(umbral_high_out),
        .umbral_low_out (umbral_low_out),
        .state_out      (state_out),
        .idle_out       (idle_out),
        .active_out     (active_out),
        .error_out      (error_out),
        .error_full     (error_full),
        .pause          (pause)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [2:0]    st;
        logic [NF-1:0] pz;
        logic [NF-1:0] ef;
        logic [TW-1:0] hi;
        logic [TW-1:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s got=%0h expected=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expectation per rising edge, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.nm, "state",  32'(state_out),       32'(e.st));
            cmp(e.nm, "idle",   32'(idle_out),        32'(e.st == 3'd2));
            cmp(e.nm, "active", 32'(active_out),      32'(e.st == 3'd3));
            cmp(e.nm, "error",  32'(error_out),       32'(e.st == 3'd4));
            cmp(e.nm, "pause",  32'(pause),           32'(e.pz));
            cmp(e.nm, "efull",  32'(error_full),      32'(e.ef));
            cmp(e.nm, "high",   32'(umbral_high_out), 32'(e.hi));
            cmp(e.nm, "low",    32'(umbral_low_out),  32'(e.lo));
        end
    end

    // Queue the expectation for the coming edge, then advance past it.
    task automatic step(input string nm, input logic [2:0] st, input logic [NF-1:0] pz,
                        input logic [NF-1:0] ef, input logic [TW-1:0] hi, input logic [TW-1:0] lo);
        exp_t e;
        e.nm = nm; e.st = st; e.pz = pz; e.ef = ef; e.hi = hi; e.lo = lo;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] occ2(input logic [CW-1:0] v);
        logic [TW-1:0] r;
        r = '0;
        r[2*CW +: CW] = v;
        return r;
    endfunction

    initial begin
        reset = 1'b1; init = 1'b0; fifo_empty = 5'b11111; fifo_error = '0;
        fifo_occ = '0; umbral_high_in = H9; umbral_low_in = L3;

        // Reset, overriding init and errors.
        step("rst1", 3'd0, 5'b0, 5'b0, '0, '0);
        init = 1'b1; fifo_error = 5'b11111;
        step("rst2", 3'd0, 5'b0, 5'b0, '0, '0);
        reset = 1'b0; fifo_error = '0;
        step("init_entry", 3'd1, 5'b0, 5'b0, '0, '0);
        step("init_load",  3'd1, 5'b0, 5'b0, H9, L3);
        init = 1'b0;
        step("to_idle",    3'd2, 5'b0, 5'b0, H9, L3);
        step("idle_stay",  3'd2, 5'b0, 5'b0, H9, L3);

        // Idle qualification: 4 consecutive all-empty edges.
        fifo_empty = 5'b11110;
        step("act_a", 3'd3, 5'b0, 5'b0, H9, L3);
        fifo_empty = 5'b11111;
        for (int k = 0; k < 3; k++) step("qual_a", 3'd3, 5'b0, 5'b0, H9, L3);
        step("idle_a", 3'd2, 5'b0, 5'b0, H9, L3);

        // Counter restart after a non-empty edge.
        fifo_empty = 5'b11110;
        step("act_b", 3'd3, 5'b0, 5'b0, H9, L3);
        fifo_empty = 5'b11111;
        for (int k = 0; k < 3; k++) step("qual_b", 3'd3, 5'b0, 5'b0, H9, L3);
        fifo_empty = 5'b11110;
        step("restart", 3'd3, 5'b0, 5'b0, H9, L3);
        fifo_empty = 5'b11111;
        for (int k = 0; k < 3; k++) step("qual_c", 3'd3, 5'b0, 5'b0, H9, L3);
        step("idle_c", 3'd2, 5'b0, 5'b0, H9, L3);

        // Hysteresis on FIFO 2.
        fifo_empty = 5'b11011;
        fifo_occ = occ2(4'd8);  step("hys8",  3'd3, 5'b00000, 5'b0, H9, L3);
        fifo_occ = occ2(4'd9);  step("hys9",  3'd3, 5'b00100, 5'b0, H9, L3);
        fifo_occ = occ2(4'd5);  step("hys5",  3'd3, 5'b00100, 5'b0, H9, L3);
        fifo_occ = occ2(4'd4);  step("hys4",  3'd3, 5'b00100, 5'b0, H9, L3);
        fifo_occ = occ2(4'd3);  step("hys3",  3'd3, 5'b00000, 5'b0, H9, L3);
        fifo_occ = occ2(4'd12); step("hys12", 3'd3, 5'b00100, 5'b0, H9, L3);

        // Sticky error; init ignored; pause frozen.
        fifo_error = 5'b10010;
        step("err",      3'd4, 5'b00100, 5'b10010, H9, L3);
        fifo_error = '0; init = 1'b1; fifo_occ = '0;
        step("err_init1", 3'd4, 5'b00100, 5'b10010, H9, L3);
        step("err_init2", 3'd4, 5'b00100, 5'b10010, H9, L3);
        reset = 1'b1; init = 1'b0; fifo_empty = 5'b11111;
        step("err_rst",  3'd0, 5'b0, 5'b0, '0, '0);

        // Error beats init from IDLE.
        reset = 1'b0; init = 1'b1;
        step("re_init",  3'd1, 5'b0, 5'b0, '0, '0);
        init = 1'b0;
        step("re_idle",  3'd2, 5'b0, 5'b0, H9, L3);
        init = 1'b1; fifo_error = 5'b00001;
        step("err_vs_init", 3'd4, 5'b0, 5'b00001, H9, L3);
        reset = 1'b1; init = 1'b0; fifo_error = '0;
        step("rst3",     3'd0, 5'b0, 5'b0, '0, '0);
        reset = 1'b0;
        step("init3",    3'd1, 5'b0, 5'b0, '0, '0);
        step("idle3",    3'd2, 5'b0, 5'b0, H9, L3);

        // Init beats activity from IDLE; pause forced to 0 in INIT.
        fifo_occ = occ2(4'd12);
        step("idle_pz",  3'd2, 5'b00100, 5'b0, H9, L3);
        init = 1'b1; fifo_empty = 5'b11101;
        step("init_vs_act", 3'd1, 5'b00100, 5'b0, H9, L3);
        umbral_high_in = HD; umbral_low_in = LD;
        step("init_pz0", 3'd1, 5'b00000, 5'b0, HD, LD);

        // Degenerate thresholds on FIFO 0: high=4, low=6.
        init = 1'b0; fifo_empty = 5'b11111; fifo_occ = '0;
        step("deg_idle", 3'd2, 5'b0, 5'b0, HD, LD);
        fifo_empty = 5'b11110;
        fifo_occ = 20'h00005; step("deg5", 3'd3, 5'b00001, 5'b0, HD, LD);
        fifo_occ = 20'h00006; step("deg6", 3'd3, 5'b00001, 5'b0, HD, LD);
        fifo_occ = 20'h00004; step("deg4", 3'd3, 5'b00001, 5'b0, HD, LD);
        fifo_occ = 20'h00003; step("deg3", 3'd3, 5'b00000, 5'b0, HD, LD);
        fifo_occ = 20'h00006; step("deg6b", 3'd3, 5'b00001, 5'b0, HD, LD);
        fifo_occ = 20'h00007; step("deg7", 3'd3, 5'b00001, 5'b0, HD, LD);

        // high=0: permanently paused once in IDLE.
        init = 1'b1; fifo_occ = '0; fifo_empty = 5'b11111;
        umbral_high_in = HZ; umbral_low_in = LZ;
        step("z_init",  3'd1, 5'b00000, 5'b0, HD, LD);
        init = 1'b0;
        step("z_idle",  3'd2, 5'b00000, 5'b0, HZ, LZ);
        step("z_pause", 3'd2, 5'b00001, 5'b0, HZ, LZ);
        step("z_hold",  3'd2, 5'b00001, 5'b0, HZ, LZ);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
